// File: rtl/vga_sync_gen.sv
// VGA timing generator driven by a pixel-enable strobe: sync, active-video, pixel coordinates, line/frame pulses.
// Optional macro VGA_SYNC_REG_OUT_EN registers all outputs, which then lag the counters by one pixel.
`timescale 1ns/1ps
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_param_chk
    $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last;
  logic             hs_c, vs_c, von_c;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hs_c  = (h_cnt >= HS_BEG && h_cnt <= HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vs_c  = (v_cnt >= VS_BEG && v_cnt <= VS_END) ? SYNC_POL : ~SYNC_POL;
  assign von_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);

`ifdef VGA_SYNC_REG_OUT_EN
  // Every output samples the pre-advance counters, so the set stays mutually aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else if (pix_en) begin
      hsync    <= hs_c;
      vsync    <= vs_c;
      video_on <= von_c;
      x        <= h_cnt;
      y        <= v_cnt;
    end
  end

  assign line_end  = pix_en && (x == H_LAST);
  assign frame_end = line_end && (y == V_LAST);
`else
  assign hsync     = hs_c;
  assign vsync     = vs_c;
  // Counters sit at (0,0) during reset, which would otherwise read as visible.
  assign video_on  = rst && von_c;
  assign x         = h_cnt;
  assign y         = v_cnt;
  assign line_end  = pix_en && h_last;
  assign frame_end = line_end && v_last;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing and shrunk-timing (SYNC_POL=1) instances vs. a pixel-count model.
`timescale 1ns/1ps
module tb_vga_sync_gen;
`ifdef VGA_SYNC_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {int ha, hfp, hs, hbp, va, vfp, vs, vbp; logic pol;} tim_t;
  typedef struct packed {logic hs, vs, von; logic [9:0] x, y; logic le, fe;} obs_t;
  typedef struct {int p; int x, y; logic hs, vs, von;} vec_t;

  localparam tim_t TD = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, pol:1'b0};
  localparam tim_t TS = '{ha:8, hfp:2, hs:3, hbp:3, va:6, vfp:1, vs:2, vbp:2, pol:1'b1};

  logic clk = 1'b0, rst = 1'b0, pix_en = 1'b0;
  logic hs_d, vs_d, von_d, le_d, fe_d;
  logic [9:0] x_d, y_d;
  logic hs_s, vs_s, von_s, le_s, fe_s;
  logic [4:0] x_s, y_s;
  obs_t cur_d, cur_s, sd, ss;
  int checks = 0, failures = 0;
  int n = 0, sb_p;

  always #5 clk = ~clk;

  vga_sync_gen dut_d (.clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hs_d), .vsync(vs_d),
    .video_on(von_d), .x(x_d), .y(y_d), .line_end(le_d), .frame_end(fe_d));

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
    .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1), .CNT_W(5)) dut_s (.clk(clk), .rst(rst),
    .pix_en(pix_en), .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .x(x_s), .y(y_s),
    .line_end(le_s), .frame_end(fe_s));

  assign cur_d = {hs_d, vs_d, von_d, x_d, y_d, le_d, fe_d};
  assign cur_s = {hs_s, vs_s, von_s, 5'b0, x_s, 5'b0, y_s, le_s, fe_s};

  // Expected outputs for displayed pixel index p (p<0: reset values).
  function automatic obs_t model(input tim_t t, input int p, input logic pe);
    int ht, vt, h, v;
    obs_t o;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    o = '0;
    o.hs = ~t.pol;
    o.vs = ~t.pol;
    if (p < 0) return o;
    h = p % ht;
    v = (p / ht) % vt;
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.hs  = (h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hs) ? t.pol : ~t.pol;
    o.vs  = (v >= t.va + t.vfp && v < t.va + t.vfp + t.vs) ? t.pol : ~t.pol;
    o.von = (h < t.ha) && (v < t.va);
    o.le  = pe && (h == ht - 1);
    o.fe  = o.le && (v == vt - 1);
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s n=%0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Strobe count since reset release is the whole reference state.
  always @(posedge clk or negedge rst)
    if (!rst) n <= 0;
    else if (pix_en) n <= n + 1;

  always @(negedge clk) begin
    sb_p = rst ? n - LAT : -1;
    cmp_obs("sb_d", cur_d, model(TD, sb_p, pix_en));
    cmp_obs("sb_s", cur_s, model(TS, sb_p, pix_en));
  end

  task automatic tick(input logic pe);
    pix_en = pe;
    @(negedge clk);
    sd = cur_d;
    ss = cur_s;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int guard, hs_cnt, first_hs, le_cnt, vs_cnt, von_cnt, fe_cnt, fe_x, fe_y, hold_diff;
    bit found;
    obs_t saved;
    tbl[0] = '{p:0,    x:0,   y:0, hs:1, vs:1, von:1};
    tbl[1] = '{p:639,  x:639, y:0, hs:1, vs:1, von:1};
    tbl[2] = '{p:640,  x:640, y:0, hs:1, vs:1, von:0};
    tbl[3] = '{p:655,  x:655, y:0, hs:1, vs:1, von:0};
    tbl[4] = '{p:656,  x:656, y:0, hs:0, vs:1, von:0};
    tbl[5] = '{p:751,  x:751, y:0, hs:0, vs:1, von:0};
    tbl[6] = '{p:752,  x:752, y:0, hs:1, vs:1, von:0};
    tbl[7] = '{p:799,  x:799, y:0, hs:1, vs:1, von:0};
    tbl[8] = '{p:800,  x:0,   y:1, hs:1, vs:1, von:1};
    tbl[9] = '{p:1723, x:123, y:2, hs:1, vs:1, von:1};

    // Reset state, including strobes ignored while held in reset.
    repeat (2) tick(0);
    tick(1);
    check("rst_hs_d", sd.hs, 1);   check("rst_vs_d", sd.vs, 1);
    check("rst_von_d", sd.von, 0); check("rst_x_d", sd.x, 0);
    check("rst_y_d", sd.y, 0);     check("rst_le_d", sd.le, 0);
    check("rst_hs_s", ss.hs, 0);   check("rst_vs_s", ss.vs, 0);
    tick(0);
    check("rst_hold_x", sd.x, 0);
    rst = 1'b1;

    // Boundary table on the default timing, strobe every 4th clk.
    foreach (tbl[i]) begin
      guard = 0;
      while (n < tbl[i].p + LAT && guard < 4000) begin
        tick(1); tick(0); tick(0); tick(0);
        guard++;
      end
      tick(0);
      check($sformatf("tbl%0d_x", i), sd.x, tbl[i].x);
      check($sformatf("tbl%0d_y", i), sd.y, tbl[i].y);
      check($sformatf("tbl%0d_hs", i), sd.hs, tbl[i].hs);
      check($sformatf("tbl%0d_vs", i), sd.vs, tbl[i].vs);
      check($sformatf("tbl%0d_von", i), sd.von, tbl[i].von);
    end

    // One full line: hsync width/start and a single one-clk line_end.
    rst_pulse();
    hs_cnt = 0; first_hs = -1; le_cnt = 0;
    for (int k = 0; k < 800 + LAT; k++) begin
      tick(1);
      if (sd.hs == 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = sd.x;
      end
      le_cnt += sd.le;
      repeat (3) begin tick(0); le_cnt += sd.le; end
    end
    check("line_hs_width", hs_cnt, 96);
    check("line_hs_start", first_hs, 656);
    check("line_le_count", le_cnt, 1);
    tick(0);
    check("line_wrap_x", sd.x, 0);
    check("line_wrap_y", sd.y, 1);

    // Full frame on the shrunk timing with continuous strobes.
    rst_pulse();
    vs_cnt = 0; von_cnt = 0; fe_cnt = 0; fe_x = -1; fe_y = -1;
    for (int k = 0; k < 176 + LAT; k++) begin
      tick(1);
      vs_cnt  += (ss.vs == 1'b1);
      von_cnt += ss.von;
      if (ss.fe) begin fe_cnt++; fe_x = ss.x; fe_y = ss.y; end
    end
    check("frame_vs_width", vs_cnt, 32);
    check("frame_von_count", von_cnt, 48);
    check("frame_fe_count", fe_cnt, 1);
    check("frame_fe_x", fe_x, 15);
    check("frame_fe_y", fe_y, 10);
    tick(0);
    check("frame_wrap_x", ss.x, 0);
    check("frame_wrap_y", ss.y, 0);

    // Asynchronous reset while both syncs are active.
    rst_pulse();
    guard = 0; found = 0;
    while (!found && guard < 400) begin
      tick(1);
      found = (ss.x == 11 && ss.y == 8);
      guard++;
    end
    check("mid_found", found, 1);
    check("mid_pre_hs", cur_s.hs, 1);
    check("mid_pre_vs", cur_s.vs, 1);
    rst = 1'b0;
    #1;
    check("mid_hs_s", cur_s.hs, 0); check("mid_vs_s", cur_s.vs, 0);
    check("mid_von_s", cur_s.von, 0); check("mid_x_s", cur_s.x, 0);
    check("mid_y_s", cur_s.y, 0);   check("mid_hs_d", cur_d.hs, 1);
    check("mid_le_s", cur_s.le, 0);
    #1;
    rst = 1'b1;
    tick(1);
    check("mid_resume_x", ss.x, 0);
    check("mid_resume_y", ss.y, 0);

    // Long pix_en gap at x=123: everything holds, no line_end.
    rst_pulse();
    guard = 0; found = 0;
    while (!found && guard < 1000) begin
      tick(0);
      found = (sd.x == 123);
      if (!found) tick(1);
      guard++;
    end
    check("hold_found", found, 1);
    saved = sd; hold_diff = 0; le_cnt = 0;
    repeat (1000) begin
      tick(0);
      if (sd !== saved) hold_diff++;
      le_cnt += sd.le;
    end
    check("hold_diff", hold_diff, 0);
    check("hold_le", le_cnt, 0);
    check("hold_x", sd.x, 123);

    // Random strobe density with occasional resets; scoreboard checks every clk.
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(1, 4);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 599) == 0) rst_pulse();
        tick($urandom_range(0, 3) < dens);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
